// File: rtl/clk_div_pkg.sv
// Shared defaults, half-period type and helpers for the divided-clock bank.
package clk_div_pkg;

    localparam int unsigned DIV_W_DEF    = 32;
    localparam int unsigned DEF_HALF_DEF = 10000;

    typedef logic [DIV_W_DEF-1:0] half_t;

    // Width of a channel-select field; never narrower than one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: active/pending half-period, counter, toggle and tick.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W    = DIV_W_DEF,
    parameter int unsigned DEF_HALF = DEF_HALF_DEF
) (
    input  logic             clk100MHz,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_data,
    input  logic             sync_restart,
    output logic             clk_out,
    output logic             tick,
    output logic             active
);

    localparam logic [DIV_W-1:0] DEF_VAL = DIV_W'(DEF_HALF);

    logic [DIV_W-1:0] half_q, half_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic [DIV_W-1:0] cnt_q,  cnt_d;
    logic             clk_q,  clk_d;
    logic             tick_q, tick_d;
    logic             active_q;

    // Next-state: a new half-period is only adopted at a toggle edge, on restart, or when idle.
    always_comb begin
        half_d = half_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (wr_en) begin
            pend_d = wr_data;
        end
        if (sync_restart) begin
            cnt_d  = '0;
            clk_d  = 1'b0;
            half_d = wr_en ? wr_data : pend_q;
        end else if (half_q == '0) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (wr_en) begin
                half_d = wr_data;
            end
        end else if (cnt_q == half_q - DIV_W'(1)) begin
            cnt_d  = '0;
            half_d = wr_en ? wr_data : pend_q;
            if (half_d == '0) begin
                clk_d = 1'b0;
            end else begin
                clk_d  = ~clk_q;
                tick_d = ~clk_q;
            end
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            half_q   <= DEF_VAL;
            pend_q   <= DEF_VAL;
            cnt_q    <= '0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            active_q <= (DEF_VAL != '0);
        end else begin
            half_q   <= half_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
            active_q <= (half_d != '0);
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign active  = active_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent clock dividers sharing one write port and a phase-align restart.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DIV_W    = DIV_W_DEF,
    parameter int unsigned DEF_HALF = DEF_HALF_DEF
) (
    input  logic                      clk100MHz,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [sel_w(NUM_CH)-1:0]  wr_sel,
    input  logic [DIV_W-1:0]          wr_data,
    input  logic                      sync_restart,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         active
);

    localparam int unsigned SEL_W = sel_w(NUM_CH);

    // Out-of-range selects match no channel and are therefore dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic hit;
        assign hit = wr_en && (wr_sel == SEL_W'(i));

        clk_div_ch #(
            .DIV_W    (DIV_W),
            .DEF_HALF (DEF_HALF)
        ) u_ch (
            .clk100MHz    (clk100MHz),
            .rst          (rst),
            .wr_en        (hit),
            .wr_data      (wr_data),
            .sync_restart (sync_restart),
            .clk_out      (clk_out[i]),
            .tick         (tick[i]),
            .active       (active[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench: a remaining-edges model predicts every output cycle; a monitor compares.
module tb_clk_div_bank;

    localparam int unsigned NUM_CH   = 3;
    localparam int unsigned DIV_W    = 8;
    localparam int unsigned DEF_HALF = 4;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned VW       = 3 * NUM_CH;

    logic                 clk100MHz = 1'b0;
    logic                 rst = 1'b1;
    logic                 wr_en = 1'b0;
    logic [SEL_W-1:0]     wr_sel = '0;
    logic [DIV_W-1:0]     wr_data = '0;
    logic                 sync_restart = 1'b0;
    logic [NUM_CH-1:0]    clk_out;
    logic [NUM_CH-1:0]    tick;
    logic [NUM_CH-1:0]    active;

    clk_div_bank #(
        .NUM_CH   (NUM_CH),
        .DIV_W    (DIV_W),
        .DEF_HALF (DEF_HALF)
    ) dut (
        .clk100MHz    (clk100MHz),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_data      (wr_data),
        .sync_restart (sync_restart),
        .clk_out      (clk_out),
        .tick         (tick),
        .active       (active)
    );

    always #5 clk100MHz = ~clk100MHz;

    // Model: half-periods, and how many more edges until the next toggle.
    int unsigned  m_h   [NUM_CH];
    int unsigned  m_p   [NUM_CH];
    int unsigned  m_rem [NUM_CH];
    bit           m_lvl [NUM_CH];
    bit           m_tick[NUM_CH];

    logic [VW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit done   = 0;

    task automatic step(input bit r, input bit we, input logic [SEL_W-1:0] sel,
                        input logic [DIV_W-1:0] d, input bit sy);
        logic [VW-1:0] e;
        bit hit;
        rst = r; wr_en = we; wr_sel = sel; wr_data = d; sync_restart = sy;
        for (int i = 0; i < NUM_CH; i++) begin
            hit = we && (int'(sel) == i);
            m_tick[i] = 1'b0;
            if (r) begin
                m_h[i] = DEF_HALF; m_p[i] = DEF_HALF; m_rem[i] = DEF_HALF; m_lvl[i] = 1'b0;
            end else if (sy) begin
                if (hit) m_p[i] = int'(d);
                m_h[i] = m_p[i]; m_rem[i] = m_h[i]; m_lvl[i] = 1'b0;
            end else if (m_h[i] == 0) begin
                m_lvl[i] = 1'b0;
                if (hit) begin
                    m_h[i] = int'(d); m_p[i] = int'(d); m_rem[i] = int'(d);
                end
            end else begin
                if (hit) m_p[i] = int'(d);
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0) begin
                    m_h[i] = m_p[i];
                    m_rem[i] = m_h[i];
                    if (m_h[i] == 0) begin
                        m_lvl[i] = 1'b0;
                    end else begin
                        m_tick[i] = !m_lvl[i];
                        m_lvl[i]  = !m_lvl[i];
                    end
                end
            end
            e[2*NUM_CH + i] = m_lvl[i];
            e[NUM_CH + i]   = m_tick[i];
            e[i]            = (m_h[i] != 0);
        end
        exp_q.push_back(e);
        @(negedge clk100MHz);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, '0, '0, 0);
    endtask

    task automatic wr(input logic [SEL_W-1:0] sel, input int unsigned d);
        step(0, 1, sel, DIV_W'(d), 0);
    endtask

    // Monitor: one prediction per rising edge, sampled just after the edge.
    initial begin
        logic [VW-1:0] e;
        logic [VW-1:0] got;
        forever begin
            @(posedge clk100MHz);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {clk_out, tick, active};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs cyc %0d got clk=%b tick=%b act=%b exp clk=%b tick=%b act=%b",
                             cyc, got[VW-1 -: NUM_CH], got[2*NUM_CH-1 -: NUM_CH], got[NUM_CH-1:0],
                             e[VW-1 -: NUM_CH], e[2*NUM_CH-1 -: NUM_CH], e[NUM_CH-1:0]);
                end
            end else if (!done) begin
                checks++;
                errors++;
                $display("FAIL scoreboard cyc %0d got empty queue exp prediction", cyc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SEL_W-1:0] s;
        int unsigned      d;
        // Reset dominates write and restart
        step(1, 1, 2'd0, 8'd7, 1);
        step(1, 0, '0, '0, 0);
        idle(18);
        // Slow ch0 to 5, then shorten to 2 mid half-period
        wr(2'd0, 5);
        idle(13);
        wr(2'd0, 2);
        idle(16);
        // Disable ch1, then restart it
        wr(2'd1, 0);
        idle(10);
        wr(2'd1, 3);
        idle(10);
        // Phase-aligned restart of H=3 and H=6
        wr(2'd0, 3);
        wr(2'd1, 6);
        idle(7);
        step(0, 0, '0, '0, 1);
        idle(15);
        // Restart coincident with a write
        step(0, 1, 2'd2, 8'd2, 1);
        idle(6);
        // Out-of-range select
        wr(2'd3, 1);
        idle(8);
        // H=1 with writes landing on every toggle edge
        wr(2'd2, 1);
        for (int k = 0; k < 10; k++) wr(2'd2, 1);
        idle(4);
        // Pending write discarded by a mid-period reset
        wr(2'd0, 9);
        idle(2);
        step(1, 0, '0, '0, 0);
        idle(10);
        // Randomised traffic
        for (int k = 0; k < 2000; k++) begin
            s = SEL_W'($urandom_range(3, 0));
            d = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(9, 1);
            step($urandom_range(249, 0) == 0, $urandom_range(3, 0) == 0, s, DIV_W'(d),
                 $urandom_range(59, 0) == 0);
        end
        done = 1;
        @(posedge clk100MHz);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
